// File: rtl/tictactoe_pkg.sv
// tictactoe_pkg: cell codes, game states and the eight winning lines shared by the board controller.
package tictactoe_pkg;
    localparam int CELLS = 9;
    typedef enum logic [1:0] {EMPTY = 2'b00, P1 = 2'b10, P2 = 2'b11} cell_t;
    typedef enum logic [1:0] {PLAY = 2'd0, CHECK = 2'd1, WIN = 2'd2, DRAW = 2'd3} state_t;
    // Rows, then columns, then the two diagonals; line l maps to bit l of the win mask.
    localparam logic [0:7][0:2][3:0] WIN_LINES = '{
        '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
    };
endpackage

// File: rtl/win_detect.sv
// win_detect: flags every completed line on the board and reports the code occupying it.
module win_detect import tictactoe_pkg::*; (
    input  logic [CELLS-1:0][1:0] board,
    output logic [7:0]            line_mask,
    output logic [1:0]            win_code
);
    always_comb begin
        line_mask = '0;
        win_code = EMPTY;
        for (int l = 0; l < 8; l++)
            if (board[WIN_LINES[l][0]] != EMPTY && board[WIN_LINES[l][0]] == board[WIN_LINES[l][1]]
                && board[WIN_LINES[l][1]] == board[WIN_LINES[l][2]]) begin
                line_mask[l] = 1'b1;
                win_code = board[WIN_LINES[l][0]];
            end
    end
endmodule

// File: rtl/board_controller.sv
// board_controller: tic-tac-toe game state, cursor and board registers feeding the VGA renderer.
module board_controller #(
    parameter int CELLS = 9
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iNEXT,
    input  logic                  iPLACE,
    input  logic                  iNEW_GAME,
    output logic [CELLS-1:0][1:0] board,
    output logic [3:0]            oCURSOR,
    output logic                  oTURN,
    output logic [1:0]            oSTATE,
    output logic [1:0]            oWINNER,
    output logic [7:0]            oWIN_LINE,
    output logic                  oINVALID
);
    import tictactoe_pkg::*;
    state_t     state;
    logic [3:0] moves;
    logic [7:0] line_mask;
    logic [1:0] win_code;
    win_detect u_win (.board(board), .line_mask(line_mask), .win_code(win_code));
    assign oSTATE = state;
    always_ff @(posedge iCLK) begin
        oINVALID <= 1'b0;
        if (iRST || iNEW_GAME) begin
            board     <= '0;
            oCURSOR   <= '0;
            oTURN     <= 1'b0;
            state     <= PLAY;
            oWINNER   <= EMPTY;
            oWIN_LINE <= '0;
            moves     <= '0;
        end else begin
            case (state)
                PLAY:
                    if (iPLACE) begin
                        if (board[oCURSOR] == EMPTY) begin
                            board[oCURSOR] <= oTURN ? P2 : P1;
                            moves <= moves + 4'd1;
                            state <= CHECK;
                        end else
                            oINVALID <= 1'b1;
                    end else if (iNEXT)
                        oCURSOR <= (oCURSOR == 4'd8) ? 4'd0 : oCURSOR + 4'd1;
                CHECK:
                    if (line_mask != 8'd0) begin
                        state     <= WIN;
                        oWINNER   <= win_code;
                        oWIN_LINE <= line_mask;
                    end else if (moves == 4'd9)
                        state <= DRAW;
                    else begin
                        oTURN <= ~oTURN;
                        state <= PLAY;
                    end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_board_controller.sv
// tb_board_controller: directed game scenarios checked every cycle against a behavioural game model.
module tb_board_controller;
    logic            iCLK = 1'b0;
    logic            iRST, iNEXT, iPLACE, iNEW_GAME;
    logic [8:0][1:0] board;
    logic [3:0]      oCURSOR;
    logic            oTURN, oINVALID;
    logic [1:0]      oSTATE, oWINNER;
    logic [7:0]      oWIN_LINE;

    int n_cmp = 0, n_bad = 0;
    bit active = 0;

    logic [8:0][1:0] mb;
    int   mcur, mmoves, mst;
    logic mturn, minv;
    logic [1:0] mwin;
    logic [7:0] mline;

    board_controller #(.CELLS(9)) dut (
        .iCLK(iCLK), .iRST(iRST), .iNEXT(iNEXT), .iPLACE(iPLACE), .iNEW_GAME(iNEW_GAME),
        .board(board), .oCURSOR(oCURSOR), .oTURN(oTURN), .oSTATE(oSTATE),
        .oWINNER(oWINNER), .oWIN_LINE(oWIN_LINE), .oINVALID(oINVALID)
    );

    always #5 iCLK = ~iCLK;

    function automatic bit same3(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        return a != 2'b00 && a == b && b == c;
    endfunction

    function automatic logic [7:0] lines_of(input logic [8:0][1:0] b);
        logic [7:0] m = '0;
        for (int r = 0; r < 3; r++) m[r] = same3(b[3*r], b[3*r+1], b[3*r+2]);
        for (int c = 0; c < 3; c++) m[3+c] = same3(b[c], b[c+3], b[c+6]);
        m[6] = same3(b[0], b[4], b[8]);
        m[7] = same3(b[2], b[4], b[6]);
        return m;
    endfunction

    // Game model: the square under the cursor, whose turn it is, and the outcome after each placement.
    always @(posedge iCLK) begin
        minv = 1'b0;
        if (iRST || iNEW_GAME) begin
            mb = '0; mcur = 0; mturn = 1'b0; mst = 0; mwin = 2'b00; mline = '0; mmoves = 0;
        end else if (mst == 0) begin
            if (iPLACE) begin
                if (mb[mcur] == 2'b00) begin
                    mb[mcur] = mturn ? 2'b11 : 2'b10;
                    mmoves++;
                    mst = 1;
                end else minv = 1'b1;
            end else if (iNEXT) mcur = (mcur + 1) % 9;
        end else if (mst == 1) begin
            if (lines_of(mb) != 0) begin
                mst = 2; mwin = mturn ? 2'b11 : 2'b10; mline = lines_of(mb);
            end else if (mmoves == 9) mst = 3;
            else begin mturn = ~mturn; mst = 0; end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge iCLK) if (active) begin
        chk("board", 32'(board), 32'(mb));
        chk("cursor", 32'(oCURSOR), 32'(mcur));
        chk("turn", 32'(oTURN), 32'(mturn));
        chk("state", 32'(oSTATE), 32'(mst));
        chk("winner", 32'(oWINNER), 32'(mwin));
        chk("win_line", 32'(oWIN_LINE), 32'(mline));
        chk("invalid", 32'(oINVALID), 32'(minv));
    end

    task automatic step(input logic ng, input logic pl, input logic nx);
        iNEW_GAME = ng; iPLACE = pl; iNEXT = nx;
        @(posedge iCLK); #1;
        iNEW_GAME = 0; iPLACE = 0; iNEXT = 0;
    endtask

    task automatic place_at(input int c);
        for (int k = 0; k < 9 && mcur != c; k++) step(0, 0, 1);
        step(0, 1, 0);
        step(0, 0, 0);
    endtask

    initial begin
        iRST = 1; iNEXT = 0; iPLACE = 0; iNEW_GAME = 0;
        @(posedge iCLK); @(posedge iCLK); #1;
        iRST = 0;
        active = 1;
        chk("rst_board", 32'(board), 0);
        chk("rst_cursor", 32'(oCURSOR), 0);
        chk("rst_state", 32'(oSTATE), 0);
        chk("rst_turn", 32'(oTURN), 0);
        // First place with a simultaneous next: piece lands, cursor holds.
        step(0, 1, 1);
        chk("p0_cell", 32'(board[0]), 32'h2);
        chk("p0_state", 32'(oSTATE), 1);
        chk("p0_cursor", 32'(oCURSOR), 0);
        step(0, 0, 0);
        chk("p0_back", 32'(oSTATE), 0);
        chk("p0_turn", 32'(oTURN), 1);
        for (int i = 1; i <= 9; i++) begin
            step(0, 0, 1);
            chk("walk_cursor", 32'(oCURSOR), 32'(i % 9));
        end
        step(1, 0, 0);
        place_at(4);
        step(0, 1, 0);
        chk("inv_pulse", 32'(oINVALID), 1);
        chk("inv_cell", 32'(board[4]), 32'h2);
        chk("inv_turn", 32'(oTURN), 1);
        step(0, 0, 0);
        chk("inv_clear", 32'(oINVALID), 0);
        step(1, 0, 0);
        place_at(0); place_at(3); place_at(1); place_at(4); place_at(2);
        chk("win_state", 32'(oSTATE), 2);
        chk("win_who", 32'(oWINNER), 32'h2);
        chk("win_mask", 32'(oWIN_LINE), 32'h01);
        step(0, 1, 0);
        chk("win_hold", 32'(oSTATE), 2);
        chk("win_noinv", 32'(oINVALID), 0);
        step(0, 0, 1);
        step(1, 0, 0);
        place_at(0); place_at(1); place_at(2); place_at(4); place_at(3);
        place_at(5); place_at(7); place_at(6); place_at(8);
        chk("draw_state", 32'(oSTATE), 3);
        chk("draw_who", 32'(oWINNER), 0);
        chk("draw_mask", 32'(oWIN_LINE), 0);
        step(1, 0, 0);
        place_at(0); place_at(3); place_at(1); place_at(4);
        for (int k = 0; k < 9 && mcur != 2; k++) step(0, 0, 1);
        step(0, 1, 0);
        chk("abort_check", 32'(oSTATE), 1);
        step(1, 0, 0);
        chk("abort_board", 32'(board), 0);
        chk("abort_state", 32'(oSTATE), 0);
        chk("abort_winner", 32'(oWINNER), 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0);
            chk("abort_nowin", 32'(oSTATE), 0);
        end
        @(negedge iCLK);
        active = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/board_controller.md
# board_controller

Game-state writer for the tic-tac-toe display path. It owns the 9-cell board array that the VGA renderer reads. It turns debounced single-cycle button pulses into cursor movement and piece placement, alternates players, and detects win and draw. It runs in the pixel clock domain, so `board` feeds the renderer directly with no synchronisation.

## Interface
Parameters:
- `CELLS`, 9: number of board cells, fixed 3x3, indexed row-major 0..8.

Ports:
- `iCLK`  in  1  single clock, the VGA pixel clock.
- `iRST`  in  1  reset, synchronous, active-high.
- `iNEXT`  in  1  one-cycle pulse; advance the cursor.
- `iPLACE`  in  1  one-cycle pulse; place the current player's piece at the cursor.
- `iNEW_GAME`  in  1  one-cycle pulse; clear the board and restart.
- `board`  out  [1:0] x [8:0]  cell codes: 00 empty, 10 player 1, 11 player 2. Code 01 is never driven.
- `oCURSOR`  out  4  cursor cell index, 0..8.
- `oTURN`  out  1  0 = player 1 to move, 1 = player 2 to move.
- `oSTATE`  out  2  PLAY=0, CHECK=1, WIN=2, DRAW=3.
- `oWINNER`  out  2  00 none, 10 player 1, 11 player 2.
- `oWIN_LINE`  out  8  one-hot mask of the completed line: rows 0-2, cols 3-5, diag 0-4-8 = 6, diag 2-4-6 = 7.
- `oINVALID`  out  1  one-cycle pulse; a placement was rejected.

## Operation
- Reset values: all cells 00, `oCURSOR`=0, `oTURN`=0, `oSTATE`=PLAY, `oWINNER`=00, `oWIN_LINE`=0, `oINVALID`=0, internal move count 0.
- Input priority in any state: `iRST` > `iNEW_GAME` > `iPLACE` > `iNEXT`.
- `iNEW_GAME`: same effect as reset, from any state.

PLAY state:
- `iPLACE` on an empty cell:
  - write 10 (turn 0) or 11 (turn 1) to `board[oCURSOR]`;
  - increment the move count;
  - go to CHECK.
- `iPLACE` on an occupied cell: board unchanged, `oINVALID` pulses, stay in PLAY.
- `iNEXT` alone: `oCURSOR` <= (`oCURSOR`==8) ? 0 : `oCURSOR`+1.
- `iPLACE` and `iNEXT` together: the place is handled and the cursor is not moved.

CHECK state (exactly one cycle):
- Evaluate all 8 lines on the updated board. A line is complete when its 3 cells are equal and non-zero.
- Any line complete: go to WIN. `oWINNER` = the placed code. `oWIN_LINE` = the mask of all complete lines (a double line is possible).
- Otherwise, move count == 9: go to DRAW.
- Otherwise: toggle `oTURN`, return to PLAY.
- `iNEXT` and `iPLACE` are ignored in this state.

WIN / DRAW states:
- Terminal. `iNEXT` and `iPLACE` are ignored, and `oINVALID` stays 0.
- Only `iNEW_GAME` or `iRST` exit these states.

Arithmetic:
- Move count is 4 bits and never exceeds 9.
- Cursor is 4 bits; values 9..15 are unreachable.

## Timing
- All outputs are registered.
- Place accepted at edge N: `board` and `oSTATE`=CHECK are visible after edge N.
- Outcome after edge N+1: `oSTATE`, `oWINNER`, `oWIN_LINE` and `oTURN` are valid.
- Throughput: the earliest next accepted place is edge N+2.
- `oINVALID`: high for exactly the cycle after the rejecting edge.
- Cursor: updates one edge after `iNEXT`.
- The renderer may sample `board` at any cycle. Only one cell changes per edge, so no multi-cycle tearing occurs.
- `iNEW_GAME` or `iRST` during CHECK aborts the evaluation: everything returns to reset values after that edge, and no WIN or DRAW is ever reported.

## Structure
- Shared package `tictactoe_pkg`:
  - `cell_t` codes (EMPTY, P1, P2);
  - `state_t` enum;
  - `WIN_LINES` constant: 8 triples of cell indices;
  - `CELLS`.
- Sub-module `win_detect`: combinational, takes the board and returns the 8-bit line-complete mask and the winning code. Instantiated once and sampled in CHECK.
- The top level holds the FSM, cursor, turn and move counters, and the board registers.

## Test plan
- Reset, then place at cursor 0 -> `board[0]`=10, CHECK for 1 cycle, then PLAY with `oTURN`=1.
- 9 `iNEXT` pulses from cursor 0 -> `oCURSOR` steps 1..8, then wraps to 0.
- Place twice on cell 4 -> second place gives `oINVALID`=1 for one cycle, `board[4]` stays 10, `oTURN` unchanged.
- P1 takes cells 0,1,2 with P2 on 3,4 -> WIN, `oWINNER`=10, `oWIN_LINE`=8'h01; a following `iPLACE` has no effect.
- Sequence 0,1,2,4,3,5,7,6,8 alternating players -> no line complete, DRAW after the 9th move, `oWINNER`=00.
- `iNEW_GAME` asserted in the CHECK cycle of a winning move -> all cells 00 and state PLAY after the edge; WIN is never observed.
